// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: shared mode encodings and board defaults for the LED pattern generator
package led_pattern_pkg;

  localparam int LED_WIDTH_DEF     = 8;
  localparam int LED_DIV_WIDTH_DEF = 32;
  localparam int LED_TOP_1HZ_50MHZ = 49999999;

  typedef enum logic [1:0] {
    LED_MODE_COUNT  = 2'd0,
    LED_MODE_ROT    = 2'd1,
    LED_MODE_BOUNCE = 2'd2,
    LED_MODE_GRAY   = 2'd3
  } led_mode_e;

endpackage

// File: rtl/led_pattern_if.sv
// led_pattern_if: control inputs and LED outputs of the pattern generator
interface led_pattern_if #(
  parameter int width     = 8,
  parameter int div_width = 32
);

  logic [div_width-1:0] top;
  logic [1:0]           mode;
  logic                 dir;
  logic                 run;
  logic [width-1:0]     leds;
  logic                 tick;

  modport master (output top, mode, dir, run, input leds, tick);
  modport slave  (input top, mode, dir, run, output leds, tick);

endinterface

// File: rtl/led_tick.sv
// led_tick: free-running prescaler producing a single-cycle step strobe
module led_tick #(
  parameter int div_width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [div_width-1:0] top,
  input  logic                 run,
  input  logic                 clr,
  output logic                 wrap
);

  logic [div_width-1:0] cnt_q, cnt_d;

  // >= rather than == so lowering top below the count wraps at once
  assign wrap = run && !clr && (cnt_q >= top);

  // clear on mode change, hold while paused, otherwise count and wrap
  always_comb cnt_d = clr ? '0 : !run ? cnt_q : wrap ? '0 : cnt_q + div_width'(1);

  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

endmodule

// File: rtl/led_pattern.sv
// led_pattern: mode-selectable LED pattern generator with integrated prescaler
module led_pattern
  import led_pattern_pkg::*;
#(
  parameter int width     = LED_WIDTH_DEF,
  parameter int div_width = LED_DIV_WIDTH_DEF
) (
  input logic          clk,
  input logic          rst_n,
  led_pattern_if.slave bus
);

  led_mode_e        mode_q, mode_d;
  logic [width-1:0] leds_q, leds_d, b_q, b_d, nx, sh;
  logic             bdir_q, bdir_d, tick_q, tick_d;
  logic             clr, step;

  assign mode_d = led_mode_e'(bus.mode);
  assign clr    = mode_d != mode_q;

  led_tick #(.div_width(div_width)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .top  (bus.top),
    .run  (bus.run),
    .clr  (clr),
    .wrap (step)
  );

  // mode change loads the init pattern; otherwise a strobe advances the current mode
  always_comb begin
    leds_d = leds_q;
    b_d    = b_q;
    bdir_d = bdir_q;
    tick_d = step;
    nx     = bus.dir ? b_q - width'(1) : b_q + width'(1);
    sh     = bdir_q ? leds_q >> 1 : leds_q << 1;
    if (clr) begin
      leds_d = (mode_d == LED_MODE_ROT || mode_d == LED_MODE_BOUNCE) ? width'(1) : '0;
      b_d    = '0;
      bdir_d = 1'b0;
    end else if (step) begin
      case (mode_q)
        LED_MODE_COUNT:  leds_d = bus.dir ? leds_q - width'(1) : leds_q + width'(1);
        LED_MODE_ROT:    leds_d = bus.dir ? {leds_q[0], leds_q[width-1:1]}
                                          : {leds_q[width-2:0], leds_q[width-1]};
        LED_MODE_BOUNCE: begin
          leds_d = sh;
          bdir_d = sh[width-1] ? 1'b1 : sh[0] ? 1'b0 : bdir_q;
        end
        default: begin
          b_d    = nx;
          leds_d = nx ^ (nx >> 1);
        end
      endcase
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= LED_MODE_COUNT;
      leds_q <= '0;
      b_q    <= '0;
      bdir_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      leds_q <= leds_d;
      b_q    <= b_d;
      bdir_q <= bdir_d;
      tick_q <= tick_d;
    end

  assign bus.leds = leds_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern.sv
// tb_led_pattern: randomized self-checking bench against a step-index reference model
module tb_led_pattern;

  localparam int W  = 8;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_pattern_if #(.width(W), .div_width(DW)) bus ();
  led_pattern #(.width(W), .div_width(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // model: pattern is a pure function of mode and a signed step index k
  int            m_mode = 0;
  int            m_k    = 0;
  logic [DW-1:0] m_cnt  = '0;
  logic          m_tick = 1'b0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_mode <= 0; m_k <= 0; m_cnt <= '0; m_tick <= 1'b0;
    end else if (int'(bus.mode) != m_mode) begin
      m_mode <= int'(bus.mode); m_k <= 0; m_cnt <= '0; m_tick <= 1'b0;
    end else if (bus.run) begin
      if (m_cnt >= bus.top) begin
        m_cnt  <= '0;
        m_tick <= 1'b1;
        m_k    <= m_k + ((m_mode == 2 || !bus.dir) ? 1 : -1);
      end else begin
        m_cnt  <= m_cnt + 1;
        m_tick <= 1'b0;
      end
    end else m_tick <= 1'b0;

  function automatic logic [W-1:0] pat(int m, int k);
    logic [W-1:0] b;
    int r, p;
    b = W'(k);
    r = ((k % W) + W) % W;
    p = ((k % (2*W-2)) + (2*W-2)) % (2*W-2);
    if (p >= W) p = 2*W-2-p;
    case (m)
      0:       return b;
      1:       return W'(1) << r;
      2:       return W'(1) << p;
      default: return b ^ (b >> 1);
    endcase
  endfunction

  task automatic test_reset();
    bus.top = 3; bus.mode = 2'd0; bus.dir = 1'b0; bus.run = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.leds !== '0 || bus.tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold leds=%h tick=%b want 00/0", bus.leds, bus.tick);
    end
    rst_n = 1'b1;
    repeat (22) begin
      @(negedge clk); n_tests++;
      if (bus.leds !== pat(m_mode, m_k) || bus.tick !== m_tick) begin
        n_fail++; $display("FAIL reset_run leds=%h tick=%b want %h/%b", bus.leds, bus.tick, pat(m_mode, m_k), m_tick);
      end
    end
    @(posedge clk); #2 rst_n = 1'b0; #1;
    n_tests++;
    if (bus.leds !== '0 || bus.tick !== 1'b0) begin
      n_fail++; $display("FAIL reset_async leds=%h tick=%b want 00/0", bus.leds, bus.tick);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_count_wrap();
    logic [W-1:0] prev;
    bit saw_wrap = 0;
    prev = bus.leds;
    repeat (1100) begin
      @(negedge clk); n_tests++;
      if (bus.leds !== pat(m_mode, m_k) || bus.tick !== m_tick) begin
        n_fail++; $display("FAIL count leds=%h tick=%b want %h/%b", bus.leds, bus.tick, pat(m_mode, m_k), m_tick);
      end
      if (prev == 8'hFF && bus.leds == 8'h00) saw_wrap = 1;
      prev = bus.leds;
    end
    n_tests++;
    if (saw_wrap !== 1'b1) begin
      n_fail++; $display("FAIL count_wrap seen=%0d want 1", saw_wrap);
    end
  endtask

  task automatic test_gray_down();
    logic [W-1:0] exp_seq [4] = '{8'h80, 8'h81, 8'h83, 8'h82};
    logic [W-1:0] prev;
    bus.mode = 2'd3; bus.dir = 1'b1; bus.top = 0;
    @(negedge clk); n_tests++;
    if (bus.leds !== 8'h00 || bus.tick !== 1'b0) begin
      n_fail++; $display("FAIL gray_init leds=%h tick=%b want 00/0", bus.leds, bus.tick);
    end
    foreach (exp_seq[i]) begin
      @(negedge clk); n_tests++;
      if (bus.leds !== exp_seq[i] || bus.tick !== 1'b1) begin
        n_fail++; $display("FAIL gray_down[%0d] leds=%h tick=%b want %h/1", i, bus.leds, bus.tick, exp_seq[i]);
      end
    end
    prev = bus.leds;
    repeat (60) begin
      bus.dir = 1'($urandom);
      @(negedge clk); n_tests++;
      if (bus.leds !== pat(m_mode, m_k) || $countones(bus.leds ^ prev) != 1) begin
        n_fail++; $display("FAIL gray_rand leds=%h prev=%h want %h one-bit change", bus.leds, prev, pat(m_mode, m_k));
      end
      prev = bus.leds;
    end
  endtask

  task automatic test_rotate();
    logic [W-1:0] e;
    bus.mode = 2'd1; bus.dir = 1'b0; bus.top = 0;
    @(negedge clk); n_tests++;
    if (bus.leds !== 8'h01 || bus.tick !== 1'b0) begin
      n_fail++; $display("FAIL rot_init leds=%h tick=%b want 01/0", bus.leds, bus.tick);
    end
    for (int i = 1; i <= 15; i++) begin
      e = W'(1) << (i % W);
      @(negedge clk); n_tests++;
      if (bus.leds !== e || bus.tick !== 1'b1) begin
        n_fail++; $display("FAIL rot_left[%0d] leds=%h tick=%b want %h/1", i, bus.leds, bus.tick, e);
      end
    end
    bus.dir = 1'b1;
    @(negedge clk); n_tests++;
    if (bus.leds !== 8'h40) begin
      n_fail++; $display("FAIL rot_flip leds=%h want 40", bus.leds);
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] exp_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    bus.mode = 2'd2; bus.top = 1; bus.dir = 1'($urandom);
    @(negedge clk); n_tests++;
    if (bus.leds !== 8'h01 || bus.tick !== 1'b0) begin
      n_fail++; $display("FAIL bounce_init leds=%h tick=%b want 01/0", bus.leds, bus.tick);
    end
    foreach (exp_seq[i]) begin
      bus.dir = 1'($urandom);
      @(negedge clk); n_tests++;
      if (bus.tick !== 1'b0) begin
        n_fail++; $display("FAIL bounce_gap[%0d] tick=%b want 0", i, bus.tick);
      end
      @(negedge clk); n_tests++;
      if (bus.leds !== exp_seq[i] || bus.tick !== 1'b1) begin
        n_fail++; $display("FAIL bounce[%0d] leds=%h tick=%b want %h/1", i, bus.leds, bus.tick, exp_seq[i]);
      end
    end
  endtask

  task automatic test_pause_top();
    logic [W-1:0]  l0;
    logic [DW-1:0] c0;
    int            budget;
    bus.run = 1'b0;
    @(negedge clk);
    l0 = pat(m_mode, m_k); c0 = m_cnt;
    repeat (20) begin
      @(negedge clk); n_tests++;
      if (bus.leds !== l0 || bus.tick !== 1'b0 || dut.u_tick.cnt_q !== c0) begin
        n_fail++; $display("FAIL pause leds=%h tick=%b cnt=%0d want %h/0/%0d", bus.leds, bus.tick, dut.u_tick.cnt_q, l0, c0);
      end
    end
    bus.run = 1'b1; bus.top = 10;
    budget = 40;
    while (m_cnt != 7 && budget > 0) begin @(negedge clk); budget--; end
    n_tests++;
    if (budget == 0) begin
      n_fail++; $display("FAIL top_wait cnt=%0d want 7", m_cnt);
    end
    bus.top = 2;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); n_tests++;
      if (bus.tick !== (i % 3 == 0) || bus.leds !== pat(m_mode, m_k)) begin
        n_fail++; $display("FAIL top_drop[%0d] tick=%b leds=%h want %b/%h", i, bus.tick, bus.leds, i % 3 == 0, pat(m_mode, m_k));
      end
    end
  endtask

  task automatic test_mode_wrap();
    int budget;
    bus.mode = 2'd0; bus.top = 3; bus.run = 1'b1;
    budget = 20;
    do begin @(negedge clk); budget--; end while (m_cnt != 3 && budget > 0);
    n_tests++;
    if (budget == 0) begin
      n_fail++; $display("FAIL wrap_wait cnt=%0d want 3", m_cnt);
    end
    bus.mode = 2'd2;
    @(negedge clk); n_tests++;
    if (bus.leds !== 8'h01 || bus.tick !== 1'b0 || dut.u_tick.cnt_q !== '0) begin
      n_fail++; $display("FAIL mode_wrap leds=%h tick=%b cnt=%0d want 01/0/0", bus.leds, bus.tick, dut.u_tick.cnt_q);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); n_tests++;
      if (bus.tick !== (i == 4) || bus.leds !== (i == 4 ? 8'h02 : 8'h01)) begin
        n_fail++; $display("FAIL mode_wrap_step[%0d] tick=%b leds=%h want %b/%h", i, bus.tick, bus.leds, i == 4, i == 4 ? 8'h02 : 8'h01);
      end
    end
  endtask

  task automatic test_random();
    repeat (600) begin
      if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(0, 7) == 0) bus.top = $urandom_range(0, 3);
      bus.dir = 1'($urandom);
      bus.run = ($urandom_range(0, 7) != 0);
      @(negedge clk); n_tests++;
      if (bus.leds !== pat(m_mode, m_k) || bus.tick !== m_tick ||
          ((m_mode == 1 || m_mode == 2) && !$onehot(bus.leds))) begin
        n_fail++; $display("FAIL random mode=%0d leds=%h tick=%b want %h/%b", m_mode, bus.leds, bus.tick, pat(m_mode, m_k), m_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_gray_down();
    test_rotate();
    test_bounce();
    test_pause_top();
    test_mode_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
